char_uart_rx: RTL and testbench
===============================

Name: char_uart_rx

Overview:
- Serial character front end placed directly upstream of the identifier recogniser.
- Receives an asynchronous 8N1 serial line, deserialises one character per frame, and presents it on an 8-bit bus.
- char_out is held between frames. The recogniser's letter and digit classes are self-looping, so re-presenting the same character every clock does not change its result; holding is therefore safe and no enable is needed downstream.
- char_valid and frame_err are provided for counters and diagnostics.

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit. Must be even and >= 4.
- Internal widths derive from CLKS_PER_BIT: counter width = $clog2(CLKS_PER_BIT). Data width is fixed at 8.

Ports:
- clk  input  1  rising-edge clock, single domain
- reset  input  1  synchronous, active-high; clears all state on the next rising clk edge
- rxd  input  1  asynchronous serial line; idles high; frames are LSB-first 8N1
- char_out  output  8  last correctly received character; held until the next good frame
- char_valid  output  1  one-cycle pulse when char_out updates
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low
- busy  output  1  high in every state except IDLE

Behaviour:
- Synchroniser
  - rxd passes through a 2-FF synchroniser; both FFs reset to 1.
  - All logic uses the synchronised value rs. Latency from rxd pin to rs is 2 cycles.
- Reset values: state=IDLE, char_out=8'h00, char_valid=0, frame_err=0, busy=0, counter=0, bit_idx=0, shift=0.
  - Reset asserted mid-frame aborts the frame. No pulse is emitted for the aborted frame.
- State machine (one-hot or encoded; encodings live in the package):
  - IDLE: rs==0 -> START, counter=0.
  - START: counter increments each cycle. At counter==CLKS_PER_BIT/2-1 (mid start bit), sample rs:
    - rs==0 -> DATA, counter=0, bit_idx=0.
    - rs==1 -> IDLE (glitch rejected, no outputs).
  - DATA: at counter==CLKS_PER_BIT-1, sample rs into shift[bit_idx] (LSB first), counter=0, bit_idx++. After bit_idx 7 is sampled -> STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rs:
    - rs==1 -> char_out<=shift, char_valid=1 for the next cycle, -> IDLE.
    - rs==0 -> frame_err=1 for the next cycle, char_out unchanged, -> BREAK.
  - BREAK: wait for rs==1, then -> IDLE. Guarantees a single frame_err per held-low line.
- Timing
  - Start edge is seen on rs at cycle t.
  - Data bit k (k=0..7) is sampled at t+CLKS_PER_BIT/2+(k+1)*CLKS_PER_BIT.
  - Stop bit is sampled at t+CLKS_PER_BIT/2+9*CLKS_PER_BIT.
  - char_valid is high in the cycle after the stop-bit sample.
- Back-to-back frames
  - A start bit immediately following the stop bit is accepted.
  - IDLE is entered mid stop bit, so a falling edge arriving up to half a bit later is caught.
- char_valid and frame_err are never high together and are never high for more than 1 cycle.
- busy = (state != IDLE), decoded from registered state.

Decomposition:
- Package char_uart_pkg:
  - State encoding constants: IDLE, START, DATA, STOP, BREAK.
  - IDLE_LEVEL = 1'b1, DATA_BITS = 8.
- Sub-module sync2: 2-FF synchroniser with a reset value parameter. Reusable for other async inputs.
- Counter, shift register and FSM stay in char_uart_rx.

Test Plan (CLKS_PER_BIT=4 for sim speed; rxd driven bit-accurately):
1. Reset, then send 0x61 ('a') -> exactly one char_valid pulse, 1 cycle after the stop sample; char_out=8'h61; frame_err stays 0; busy returns to 0.
2. Back-to-back 'x' (0x78) then '1' (0x31) with zero idle gap -> two char_valid pulses 10*CLKS_PER_BIT cycles apart; char_out=8'h78, then 8'h31.
3. rxd low for 1 cycle (less than half a bit), then high -> busy pulses briefly; no char_valid, no frame_err; char_out keeps its previous value.
4. Frame 0x41 with stop bit driven 0 -> one frame_err pulse; char_out unchanged (8'h00 after reset); state sits in BREAK while rxd stays low.
5. rxd held low for 40 bit times, then high, then valid 0x39 -> exactly one frame_err during the low period; then one char_valid with char_out=8'h39.
6. Assert reset during DATA bit 3 of 0x5A -> next cycle char_out=8'h00, busy=0, no pulses; following frame 0x5A is received correctly.

Source files
------------

// File: rtl/char_uart_pkg.sv
// char_uart_pkg
//   Shared constants for the serial character front end.
//   - FSM state encodings (plain localparams so older code that compares
//     against raw bit patterns keeps working).
//   - Line idle level and character width.
package char_uart_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] START = 3'd1;
    localparam logic [STATE_W-1:0] DATA  = 3'd2;
    localparam logic [STATE_W-1:0] STOP  = 3'd3;
    localparam logic [STATE_W-1:0] BREAK = 3'd4;

    // A UART line rests at mark (high) between frames.
    localparam logic IDLE_LEVEL = 1'b1;

    // Fixed character width; the receiver's bit index is sized for this.
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/sync2.sv
// sync2
//   Two flip-flop synchroniser for a single asynchronous input.
//   Both stages load RST_VAL on reset so the output never shows a
//   spurious edge coming out of reset.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high
//   d     - asynchronous input
//   q     - synchronised output, two clk cycles behind d
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/char_uart_rx.sv
// char_uart_rx
//   8N1 serial receiver feeding the identifier recogniser. Each good frame
//   updates char_out, which then holds until the next good frame; the
//   recogniser tolerates seeing the same character on consecutive clocks,
//   so no enable is needed downstream.
// Parameters:
//   CLKS_PER_BIT - clk cycles per serial bit; must be even and >= 4
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-high; aborts any frame in progress
//   rxd        - asynchronous serial line, idles high, LSB first
//   char_out   - last correctly received character
//   char_valid - one-cycle pulse when char_out updates
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high whenever the receiver is not idle
module char_uart_rx
    import char_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // Start bit is checked half a bit in; every later bit is one full bit
    // after the previous sample, which keeps all samples mid-bit.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rs;
    logic [STATE_W-1:0]   state;
    logic [CW-1:0]        counter;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shift;

    sync2 #(
        .RST_VAL (IDLE_LEVEL)
    ) u_rxd_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses by construction.
            char_valid <= 1'b0;
            frame_err  <= 1'b0;

            case (state)
                IDLE: begin
                    counter <= '0;
                    if (rs == 1'b0) begin
                        state <= START;
                    end
                end

                START: begin
                    if (counter == HALF_M1) begin
                        counter <= '0;
                        bit_idx <= '0;
                        // Line back high by mid start bit: treat as noise.
                        state   <= rs ? IDLE : DATA;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                DATA: begin
                    if (counter == FULL_M1) begin
                        counter        <= '0;
                        shift[bit_idx] <= rs;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            state <= STOP;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                STOP: begin
                    if (counter == FULL_M1) begin
                        counter <= '0;
                        // Returning to IDLE mid stop bit leaves half a bit of
                        // slack to catch a back-to-back start edge.
                        if (rs) begin
                            char_out   <= shift;
                            char_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end

                BREAK: begin
                    // Hold here while the line stays low so a long break
                    // produces one frame_err rather than one per frame time.
                    counter <= '0;
                    if (rs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_char_uart_rx.sv
module tb_char_uart_rx;

    localparam int C = 4;
    // Pulse appears this many clocks after the cycle the start bit is driven:
    // 2 synchroniser stages, 1 to leave IDLE, then mid start + 9 bits.
    localparam int LAT = 3 + C / 2 + 9 * C;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic [7:0] char_out;
    logic       char_valid;
    logic       frame_err;
    logic       busy;

    char_uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .char_out   (char_out),
        .char_valid (char_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] ch;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         rst_at_edge = 1'b1;
    logic [7:0] mdl_char = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = reset;
    end

    // Monitor: compare every presented pulse against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_at_edge) begin
            mdl_char = 8'h00;
            sb.delete();
            check("rst_char_out", char_out, 8'h00);
            check("rst_busy", busy, 1'b0);
            check("rst_pulses", {char_valid, frame_err}, 2'b00);
        end else begin
            if (char_valid && frame_err) check("both_pulses", 1'b1, 1'b0);
            if (char_valid || frame_err) begin
                check("pulse_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pulse_kind_err", frame_err, e.is_err);
                    check("pulse_cycle", cyc, e.cyc);
                    if (!e.is_err) mdl_char = e.ch;
                end
            end
            check("char_out_held", char_out, mdl_char);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame bit-accurately; rxd is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        e.ch     = b;
        e.cyc    = cyc + LAT;
        sb.push_back(e);
        rxd = 1'b0;
        tick(C);
        for (int k = 0; k < 8; k++) begin
            rxd = b[k];
            tick(C);
        end
        rxd = stop_ok;
        tick(C);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 30 * C && sb.size() != 0; i++) tick(1);
        check(name, sb.size(), 0);
    endtask

    initial begin
        bit seen_busy;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("reset_busy", busy, 1'b0);
        check("reset_char", char_out, 8'h00);
        check("reset_pulses", {char_valid, frame_err}, 2'b00);
        tick(2 * C);

        // 1: single character
        send_frame(8'h61, 1'b1);
        drain("t1_drain");
        tick(1);
        check("t1_char", char_out, 8'h61);
        check("t1_busy_idle", busy, 1'b0);
        tick(2 * C);

        // 2: back-to-back, no idle gap
        send_frame(8'h78, 1'b1);
        send_frame(8'h31, 1'b1);
        drain("t2_drain");
        tick(1);
        check("t2_char", char_out, 8'h31);
        tick(2 * C);

        // 3: glitch shorter than half a bit
        seen_busy = 1'b0;
        rxd = 1'b0;
        tick(1);
        rxd = 1'b1;
        for (int i = 0; i < 3 * C; i++) begin
            if (busy) seen_busy = 1'b1;
            tick(1);
        end
        check("t3_busy_seen", seen_busy, 1'b1);
        check("t3_busy_idle", busy, 1'b0);
        check("t3_char", char_out, 8'h31);

        // 4: bad stop bit after a fresh reset, line held low afterwards
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(2 * C);
        send_frame(8'h41, 1'b0);
        drain("t4_drain");
        tick(2 * C);
        check("t4_busy_break", busy, 1'b1);
        check("t4_char", char_out, 8'h00);
        rxd = 1'b1;
        tick(4);
        check("t4_busy_idle", busy, 1'b0);
        tick(2 * C);

        // 5: long break then a good frame
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.ch     = 8'h00;
            e.cyc    = cyc + LAT;
            sb.push_back(e);
        end
        rxd = 1'b0;
        tick(40 * C);
        rxd = 1'b1;
        tick(2 * C);
        check("t5_one_err", sb.size(), 0);
        send_frame(8'h39, 1'b1);
        drain("t5_drain");
        tick(1);
        check("t5_char", char_out, 8'h39);
        tick(2 * C);

        // 6: reset in the middle of data bit 3 of 0x5A
        begin
            logic [7:0] b;
            b = 8'h5A;
            rxd = 1'b0;
            tick(C);
            for (int k = 0; k < 3; k++) begin
                rxd = b[k];
                tick(C);
            end
            rxd = b[3];
            tick(2);
            reset = 1'b1;
            rxd = 1'b1;
            tick(1);
            reset = 1'b0;
            check("t6_busy", busy, 1'b0);
            check("t6_char", char_out, 8'h00);
            tick(2 * C);
            send_frame(b, 1'b1);
            drain("t6_drain");
            tick(1);
            check("t6_char_after", char_out, 8'h5A);
        end
        tick(2 * C);

        // Randomised frames, gaps and occasional bad stop bits.
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            bit         ok;
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (!ok) begin
                tick(C * $urandom_range(0, 3));
                rxd = 1'b1;
                tick(C);
            end
            tick(C * $urandom_range(0, 2));
        end
        drain("rand_drain");
        tick(2);
        check("rand_busy_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
